// File: rtl/afg_pkg.sv
// Shared types and constants for the waveform generator datapath.
package afg_pkg;

  localparam int PHASE_W = 14;
  localparam int OUT_W   = 14;
  localparam int ROM_AW  = 12;
  localparam int MAG_W   = OUT_W - 1;
  localparam int AMP_W   = 8;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    TRI    = 2'd1,
    SAW    = 2'd2,
    SQUARE = 2'd3
  } wave_mode_t;

  localparam logic [OUT_W-1:0] SQUARE_POS = 14'h1FFF;  // +8191
  localparam logic [OUT_W-1:0] SQUARE_NEG = 14'h2001;  // -8191
  localparam logic [OUT_W-1:0] WAVE_OFFSET = 14'h2000; // 8192

endpackage

// File: rtl/waveform_shaper_if.sv
// Sample-stream, configuration and external ROM signals of the waveform shaper.
interface waveform_shaper_if;
  import afg_pkg::*;

  logic [PHASE_W-1:0] Phase_in;
  logic               Phase_valid;
  logic               Wrap_in;
  logic [1:0]         Mode_in;
  logic [AMP_W-1:0]   Amp_in;
  logic               Mode_load;
  logic [ROM_AW-1:0]  Rom_addr;
  logic [MAG_W-1:0]   Rom_data;
  logic [OUT_W-1:0]   Wave_out;
  logic               Wave_valid;
  logic [1:0]         Mode_active;

  modport slave (
    input  Phase_in, Phase_valid, Wrap_in, Mode_in, Amp_in, Mode_load, Rom_data,
    output Rom_addr, Wave_out, Wave_valid, Mode_active
  );

  modport master (
    output Phase_in, Phase_valid, Wrap_in, Mode_in, Amp_in, Mode_load, Rom_data,
    input  Rom_addr, Wave_out, Wave_valid, Mode_active
  );

endinterface

// File: rtl/wave_amp_scaler.sv
// Registered gain stage: sample * (amp + 1), arithmetic shift right by 8.
module wave_amp_scaler
  import afg_pkg::*;
(
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic signed [OUT_W-1:0] rawIn,
  input  logic [AMP_W-1:0]        ampIn,
  input  logic                    validIn,
  output logic [OUT_W-1:0]        Wave_out,
  output logic                    Wave_valid
);

  logic [AMP_W:0]     gain;
  logic signed [22:0] rawExt;
  logic signed [22:0] gainExt;
  logic signed [22:0] product;

  assign gain    = {1'b0, ampIn} + 9'd1;
  assign rawExt  = 23'(rawIn);
  assign gainExt = $signed(23'(gain));
  assign product = rawExt * gainExt;

  // Output holds its last value across bubbles; only the valid strobe drops.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Wave_out   <= '0;
      Wave_valid <= 1'b0;
    end else begin
      Wave_valid <= validIn;
      if (validIn) Wave_out <= OUT_W'(product >>> 8);
    end
  end

endmodule

// File: rtl/waveform_shaper.sv
// Phase-to-sample shaper: deferred mode/amp commit, ROM addressing, raw wave select, scaling.
module waveform_shaper
  import afg_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  waveform_shaper_if.slave  bus
);

  wave_mode_t         shadowMode, activeMode, sampleMode;
  logic [AMP_W-1:0]   shadowAmp, activeAmp, sampleAmp;
  logic               pendingLoad, commit;

  logic [PHASE_W-1:0] s1Phase, s2Phase;
  wave_mode_t         s1Mode, s2Mode;
  logic [AMP_W-1:0]   s1Amp, s2Amp, rawAmp;
  logic               s1Valid, s2Valid, rawValid;
  logic signed [OUT_W-1:0] raw, rawReg, romMag;
  logic [MAG_W-1:0]   triMag;

  // A load only commits at a wrap strictly after it, so the pending flag is read before update.
  assign commit     = bus.Phase_valid & bus.Wrap_in & pendingLoad;
  assign sampleMode = commit ? shadowMode : activeMode;
  assign sampleAmp  = commit ? shadowAmp  : activeAmp;
  assign bus.Mode_active = activeMode;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shadowMode  <= SINE;
      shadowAmp   <= 8'd255;
      activeMode  <= SINE;
      activeAmp   <= 8'd255;
      pendingLoad <= 1'b0;
    end else begin
      if (bus.Mode_load) begin
        shadowMode <= wave_mode_t'(bus.Mode_in);
        shadowAmp  <= bus.Amp_in;
      end
      if (commit) begin
        activeMode <= shadowMode;
        activeAmp  <= shadowAmp;
      end
      pendingLoad <= bus.Mode_load | (pendingLoad & ~commit);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s1Phase      <= '0;
      s1Mode       <= SINE;
      s1Amp        <= '0;
      s1Valid      <= 1'b0;
      s2Phase      <= '0;
      s2Mode       <= SINE;
      s2Amp        <= '0;
      s2Valid      <= 1'b0;
      rawReg       <= '0;
      rawAmp       <= '0;
      rawValid     <= 1'b0;
      bus.Rom_addr <= '0;
    end else begin
      s1Phase  <= bus.Phase_in;
      s1Mode   <= sampleMode;
      s1Amp    <= sampleAmp;
      s1Valid  <= bus.Phase_valid;
      s2Phase  <= s1Phase;
      s2Mode   <= s1Mode;
      s2Amp    <= s1Amp;
      s2Valid  <= s1Valid;
      rawReg   <= raw;
      rawAmp   <= s2Amp;
      rawValid <= s2Valid;
      // Odd quadrants read the quarter wave backwards.
      if (bus.Phase_valid)
        bus.Rom_addr <= bus.Phase_in[PHASE_W-2] ? ~bus.Phase_in[ROM_AW-1:0]
                                                 :  bus.Phase_in[ROM_AW-1:0];
    end
  end

  assign romMag = $signed({1'b0, bus.Rom_data});
  assign triMag = s2Phase[PHASE_W-1] ? ~s2Phase[MAG_W-1:0] : s2Phase[MAG_W-1:0];

  always_comb begin
    raw = '0;
    unique case (s2Mode)
      SINE:    raw = s2Phase[PHASE_W-1] ? -romMag : romMag;
      TRI:     raw = $signed({triMag, 1'b0} - WAVE_OFFSET);
      SAW:     raw = $signed({~s2Phase[PHASE_W-1], s2Phase[MAG_W-1:0]});
      SQUARE:  raw = $signed(s2Phase[PHASE_W-1] ? SQUARE_NEG : SQUARE_POS);
      default: raw = '0;
    endcase
  end

  wave_amp_scaler u_scaler (
    .Clock      (Clock),
    .Reset      (Reset),
    .rawIn      (rawReg),
    .ampIn      (rawAmp),
    .validIn    (rawValid),
    .Wave_out   (bus.Wave_out),
    .Wave_valid (bus.Wave_valid)
  );

endmodule
